fft_frame_feeder: RTL and testbench
===================================

// Module: fft_frame_feeder
// PURPOSE
//  Downstream of the windowing/float-conversion stage: takes the synchronous CHA/CHB float sample
//  streams (valid-only, no backpressure) with the per-frame last strobe, buffers them in a shared
//  FIFO and drives two AXI4-Stream data ports (one per FFT core) plus the FFT config channel.
//  Absorbs FFT tready stalls, checks frame length, flags overflow and channel desync.
// PARAMETERS
//  DATA_W      32     width of one float sample per channel
//  FRAME_LEN   256    samples per frame (window length)
//  FIFO_AW     9      FIFO address bits; depth = 2**FIFO_AW entries of {last,B,A}
//  CFG_W       8      FFT config tdata width
//  CFG_VALUE   8'h01  config word sent to both cores (bit0=1: forward transform)
// PORTS
//  clk            in   1        clock, all logic on rising edge
//  rst_n          in   1        reset, asynchronous, active-low
//  in_a_data      in   DATA_W   CHA float sample
//  in_a_valid     in   1        CHA sample valid; governs FIFO writes
//  in_b_data      in   DATA_W   CHB float sample
//  in_b_valid     in   1        CHB sample valid; expected equal to in_a_valid
//  in_last        in   1        last sample of frame, qualified by in_a_valid
//  reconfig       in   1        pulse: resend config at next frame boundary
//  clear_status   in   1        pulse: clears sticky flags
//  m_cfg_tdata    out  CFG_W    config word, = CFG_VALUE, shared by both cores
//  m_cfg_tvalid   out  1        config valid
//  m_cfg_tready   in   1        AND of both cores' config tready (external)
//  m_a_tdata      out  DATA_W   CHA sample to FFT A
//  m_a_tvalid     out  1
//  m_a_tready     in   1
//  m_a_tlast      out  1
//  m_b_tdata      out  DATA_W   CHB sample to FFT B
//  m_b_tvalid     out  1
//  m_b_tready     in   1
//  m_b_tlast      out  1
//  frames_sent    out  16       frames fully emitted on both ports, wraps 0xFFFF->0
//  ovf_err        out  1        sticky: write while FIFO full (sample dropped)
//  len_err        out  1        sticky: in_last seen at sample count != FRAME_LEN
//  sync_err       out  1        sticky: in_a_valid != in_b_valid on some cycle
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, frame/sample counters 0, FSM=CFG.
//  FSM: CFG  -> m_cfg_tvalid=1 until m_cfg_tvalid&&m_cfg_tready, then RUN.
//       RUN  -> data ports active; reconfig pulse latches pending flag; when pending and the
//               entry just popped had last=1 (or FIFO empty and no partial frame output) -> CFG.
//       Data tvalids are 0 in CFG; FIFO keeps accepting writes in every state.
//  Write: in_a_valid=1 and FIFO not full -> push {in_last,in_b_data,in_a_data}. Full -> drop,
//   ovf_err=1. Full with same-cycle pop -> write accepted, count unchanged.
//  Read: first-word fall-through; written entry visible on m_*_tdata one cycle after write edge.
//   m_a_tvalid = RUN && !empty && !done_a; m_b likewise with done_b. tvalid never depends on tready.
//   A handshake sets done_a (B: done_b); entry popped when both sides have handshaken
//   (same cycle or different cycles); pop clears done_a/done_b. tlast = stored last bit on both.
//   Held data/tvalid stable while waiting for tready (AXIS rule).
//  Length check: sample counter counts accepted writes; in_last at count != FRAME_LEN-1 -> len_err;
//   counter resets to 0 on any in_last write. No in_last at FRAME_LEN-1 -> len_err, counter wraps.
//  frames_sent +1 on pop of entry with last=1.
//  Sticky flags cleared by clear_status; same-cycle new error wins (flag stays 1).
//  sync_err: set on any cycle in_a_valid != in_b_valid; write still governed by in_a_valid.
//  Reset mid-frame: FIFO and partial frame discarded, config resent before any data.
// TESTING
//  Reset, cfg_tready=1 -> m_cfg_tvalid 1 cycle with 0x01; then 256 samples+last -> 256 beats
//   each port, tlast on beat 256, frames_sent=1, no error flags.
//  m_a_tready=1, m_b_tready toggling 1-of-4 -> every entry emitted once per port, A beat not
//   repeated while done_a, data order identical on both ports.
//  Both treadys 0, write 2**FIFO_AW+3 samples -> first 512 kept, ovf_err=1, last 3 dropped.
//  in_last after 200 samples -> len_err=1; clear_status -> 0; next 256-sample frame clean.
//  reconfig mid-frame -> config beat only after tlast beat of current frame, next frame follows.
//  in_b_valid low for one cycle while in_a_valid high -> sync_err=1; rst_n low mid-frame ->
//   all outputs 0, cfg resent, frames_sent=0.

Source files
------------

// File: rtl/fft_frame_feeder.sv
// Buffers synchronous CHA/CHB float samples in a shared first-word-fall-through FIFO and feeds two
// AXI4-Stream FFT cores plus their config channel, with frame-length, overflow and desync checks.
module fft_frame_feeder #(
    parameter int               DATA_W    = 32,
    parameter int               FRAME_LEN = 256,
    parameter int               FIFO_AW   = 9,
    parameter int               CFG_W     = 8,
    parameter logic [CFG_W-1:0] CFG_VALUE = 8'h01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_a_data,
    input  logic              in_a_valid,
    input  logic [DATA_W-1:0] in_b_data,
    input  logic              in_b_valid,
    input  logic              in_last,
    input  logic              reconfig,
    input  logic              clear_status,
    output logic [CFG_W-1:0]  m_cfg_tdata,
    output logic              m_cfg_tvalid,
    input  logic              m_cfg_tready,
    output logic [DATA_W-1:0] m_a_tdata,
    output logic              m_a_tvalid,
    input  logic              m_a_tready,
    output logic              m_a_tlast,
    output logic [DATA_W-1:0] m_b_tdata,
    output logic              m_b_tvalid,
    input  logic              m_b_tready,
    output logic              m_b_tlast,
    output logic [15:0]       frames_sent,
    output logic              ovf_err,
    output logic              len_err,
    output logic              sync_err
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int ENT_W = 2 * DATA_W + 1;
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic {
        S_CFG = 1'b0,
        S_RUN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_cfg_valid;
    logic               r_pend;
    logic               r_mid_frame;
    logic               r_done_a;
    logic               r_done_b;
    logic [ENT_W-1:0]   r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic [CNT_W-1:0]   r_smp_cnt;
    logic [15:0]        r_frames;
    logic               r_ovf;
    logic               r_len;
    logic               r_sync;

    logic               w_empty;
    logic               w_full;
    logic               w_run;
    logic               w_push;
    logic               w_pop;
    logic               w_a_hs;
    logic               w_b_hs;
    logic               w_cfg_hs;
    logic               w_ovf_set;
    logic               w_len_set;
    logic               w_sync_set;
    logic               w_cnt_end;
    logic [ENT_W-1:0]   w_head;
    logic               w_head_last;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_run       = (r_state == S_RUN);
    // Head entry is forced to zero when empty so idle outputs never show stale RAM contents.
    assign w_head      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign w_head_last = w_head[ENT_W-1];

    assign m_a_tvalid  = w_run && !w_empty && !r_done_a;
    assign m_b_tvalid  = w_run && !w_empty && !r_done_b;
    assign m_a_tdata   = w_head[DATA_W-1:0];
    assign m_b_tdata   = w_head[2*DATA_W-1:DATA_W];
    assign m_a_tlast   = w_head_last;
    assign m_b_tlast   = w_head_last;
    assign m_cfg_tvalid = r_cfg_valid;
    assign m_cfg_tdata  = r_cfg_valid ? CFG_VALUE : '0;
    assign frames_sent = r_frames;
    assign ovf_err     = r_ovf;
    assign len_err     = r_len;
    assign sync_err    = r_sync;

    assign w_a_hs   = m_a_tvalid && m_a_tready;
    assign w_b_hs   = m_b_tvalid && m_b_tready;
    assign w_cfg_hs = r_cfg_valid && m_cfg_tready;
    // An entry retires only once both cores have taken it, whichever order they arrive in.
    assign w_pop    = (r_done_a || w_a_hs) && (r_done_b || w_b_hs);
    assign w_push   = in_a_valid && (!w_full || w_pop);

    assign w_cnt_end  = (r_smp_cnt == LAST_IDX);
    assign w_ovf_set  = in_a_valid && w_full && !w_pop;
    assign w_len_set  = w_push && (in_last ? !w_cnt_end : w_cnt_end);
    assign w_sync_set = (in_a_valid != in_b_valid);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CFG: if (w_cfg_hs) w_state_next = S_RUN;
            S_RUN: if (r_pend && ((w_pop && w_head_last) || (w_empty && !r_mid_frame)))
                       w_state_next = S_CFG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_CFG;
            r_cfg_valid <= 1'b0;
            r_pend      <= 1'b0;
            r_mid_frame <= 1'b0;
            r_done_a    <= 1'b0;
            r_done_b    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cfg_valid <= (w_state_next == S_CFG);
            if (r_state == S_CFG)
                r_pend <= 1'b0;
            else if (reconfig)
                r_pend <= 1'b1;
            if (w_pop) begin
                r_mid_frame <= !w_head_last;
                r_done_a    <= 1'b0;
                r_done_b    <= 1'b0;
            end else begin
                r_done_a    <= r_done_a || w_a_hs;
                r_done_b    <= r_done_b || w_b_hs;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {in_last, in_b_data, in_a_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp_cnt <= '0;
            r_frames  <= '0;
            r_ovf     <= 1'b0;
            r_len     <= 1'b0;
            r_sync    <= 1'b0;
        end else begin
            if (w_push)
                r_smp_cnt <= (in_last || w_cnt_end) ? '0 : r_smp_cnt + 1'b1;
            if (w_pop && w_head_last)
                r_frames <= r_frames + 16'd1;
            r_ovf  <= w_ovf_set  || (r_ovf  && !clear_status);
            r_len  <= w_len_set  || (r_len  && !clear_status);
            r_sync <= w_sync_set || (r_sync && !clear_status);
        end
    end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed self-checking bench for fft_frame_feeder: config, streaming, stalls, overflow,
// frame-length errors, reconfiguration and reset behaviour.
`timescale 1ns/1ps
module tb_fft_frame_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_a_data = '0;
    logic        in_a_valid = 1'b0;
    logic [31:0] in_b_data = '0;
    logic        in_b_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        reconfig = 1'b0;
    logic        clear_status = 1'b0;
    logic [7:0]  m_cfg_tdata;
    logic        m_cfg_tvalid;
    logic        m_cfg_tready = 1'b0;
    logic [31:0] m_a_tdata;
    logic        m_a_tvalid;
    logic        m_a_tready = 1'b0;
    logic        m_a_tlast;
    logic [31:0] m_b_tdata;
    logic        m_b_tvalid;
    logic        m_b_tready = 1'b0;
    logic        m_b_tlast;
    logic [15:0] frames_sent;
    logic        ovf_err;
    logic        len_err;
    logic        sync_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [32:0] qa[$];
    logic [32:0] qb[$];
    int          qa_cyc[$];
    int          qb_cyc[$];
    int          cfg_cyc[$];
    logic [64:0] exp_q[$];

    fft_frame_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .in_a_data(in_a_data), .in_a_valid(in_a_valid),
        .in_b_data(in_b_data), .in_b_valid(in_b_valid),
        .in_last(in_last), .reconfig(reconfig), .clear_status(clear_status),
        .m_cfg_tdata(m_cfg_tdata), .m_cfg_tvalid(m_cfg_tvalid), .m_cfg_tready(m_cfg_tready),
        .m_a_tdata(m_a_tdata), .m_a_tvalid(m_a_tvalid), .m_a_tready(m_a_tready), .m_a_tlast(m_a_tlast),
        .m_b_tdata(m_b_tdata), .m_b_tvalid(m_b_tvalid), .m_b_tready(m_b_tready), .m_b_tlast(m_b_tlast),
        .frames_sent(frames_sent), .ovf_err(ovf_err), .len_err(len_err), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Beat recorder: logs every completed handshake with the cycle it happened in.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_a_tvalid && m_a_tready) begin
            qa.push_back({m_a_tlast, m_a_tdata});
            qa_cyc.push_back(cyc);
        end
        if (m_b_tvalid && m_b_tready) begin
            qb.push_back({m_b_tlast, m_b_tdata});
            qb_cyc.push_back(cyc);
        end
        if (m_cfg_tvalid && m_cfg_tready)
            cfg_cyc.push_back(cyc);
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] da(input int tag, input int i);
        return 32'hA000_0000 + 32'(tag << 12) + 32'(i);
    endfunction

    function automatic logic [31:0] db(input int tag, input int i);
        return 32'hB000_0000 + 32'(tag << 12) + 32'(i);
    endfunction

    // Number of recorded beats that disagree with the expected entry list (size mismatch counts).
    function automatic int count_bad();
        int bad = 0;
        if (qa.size() != exp_q.size()) bad++;
        if (qb.size() != exp_q.size()) bad++;
        foreach (exp_q[i]) begin
            if (i < qa.size() && qa[i] !== {exp_q[i][64], exp_q[i][31:0]})  bad++;
            if (i < qb.size() && qb[i] !== {exp_q[i][64], exp_q[i][63:32]}) bad++;
        end
        return bad;
    endfunction

    task automatic clear_logs();
        qa.delete(); qb.delete(); qa_cyc.delete(); qb_cyc.delete(); exp_q.delete();
    endtask

    task automatic drive(input logic va, input logic vb, input logic [31:0] a,
                         input logic [31:0] b, input logic last);
        in_a_valid = va; in_b_valid = vb; in_a_data = a; in_b_data = b; in_last = last;
        @(posedge clk); #1;
        in_a_valid = 1'b0; in_b_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(input int tag, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, da(tag, i), db(tag, i), i == n - 1);
            exp_q.push_back({i == n - 1, db(tag, i), da(tag, i)});
        end
    endtask

    task automatic wait_frames(input logic [15:0] target, input int maxc);
        int n = 0;
        while (frames_sent !== target && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        @(posedge clk); #1;
        clear_status = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_cfg_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_cfg_tvalid !== 1'b0 || m_a_tvalid !== 1'b0 || m_b_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: cfg=%b a=%b b=%b required 000", m_cfg_tvalid, m_a_tvalid, m_b_tvalid);
        end
        checks++;
        if (m_a_tdata !== 32'h0 || m_b_tdata !== 32'h0 || m_cfg_tdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h cfg=%h required 0", m_a_tdata, m_b_tdata, m_cfg_tdata);
        end
        checks++;
        if (frames_sent !== 16'd0 || {ovf_err, len_err, sync_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: frames=%0d flags=%b required 0 000", frames_sent, {ovf_err, len_err, sync_err});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (m_cfg_tvalid !== 1'b1 || m_cfg_tdata !== 8'h01) begin
            errors++;
            $display("FAIL cfg_beat: valid=%b data=%h required 1 01", m_cfg_tvalid, m_cfg_tdata);
        end
        @(posedge clk); #1;
        checks++;
        if (m_cfg_tvalid !== 1'b0 || cfg_cyc.size() != 1) begin
            errors++;
            $display("FAIL cfg_once: valid=%b beats=%0d required 0 1", m_cfg_tvalid, cfg_cyc.size());
        end
    endtask

    task automatic test_basic();
        int bad;
        clear_logs();
        m_a_tready = 1'b1; m_b_tready = 1'b1;
        send_frame(1, 256);
        wait_frames(16'd1, 1000);
        checks++;
        if (frames_sent !== 16'd1) begin
            errors++;
            $display("FAIL basic_frames: got %0d required 1", frames_sent);
        end
        bad = count_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL basic_data: bad beats=%0d (a=%0d b=%0d) required 0", bad, qa.size(), qb.size());
        end
        checks++;
        if ({ovf_err, len_err, sync_err} !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags: got %b required 000", {ovf_err, len_err, sync_err});
        end
    endtask

    task automatic test_stall();
        int bad;
        int k = 0;
        clear_logs();
        m_a_tready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            m_b_tready = (k % 4 == 0);
            k++;
            drive(1'b1, 1'b1, da(2, i), db(2, i), i == 255);
            exp_q.push_back({i == 255, db(2, i), da(2, i)});
        end
        while (frames_sent !== 16'd2 && k < 3000) begin
            m_b_tready = (k % 4 == 0);
            k++;
            @(posedge clk); #1;
        end
        m_b_tready = 1'b1;
        checks++;
        if (frames_sent !== 16'd2) begin
            errors++;
            $display("FAIL stall_frames: got %0d required 2", frames_sent);
        end
        bad = count_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_data: bad beats=%0d (a=%0d b=%0d) required 0", bad, qa.size(), qb.size());
        end
    endtask

    task automatic test_overflow();
        int bad;
        clear_logs();
        m_a_tready = 1'b0; m_b_tready = 1'b0;
        for (int i = 0; i < 515; i++) begin
            logic lst;
            int tag;
            lst = (i == 255) || (i == 511);
            tag = (i < 256) ? 3 : 4;
            drive(1'b1, 1'b1, da(tag, i % 256), db(tag, i % 256), lst);
            if (i < 512)
                exp_q.push_back({lst, db(tag, i % 256), da(tag, i % 256)});
            if (i == 511) begin
                checks++;
                if (ovf_err !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: got %b required 0 after 512 writes", ovf_err);
                end
            end
        end
        checks++;
        if (ovf_err !== 1'b1 || len_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flag: ovf=%b len=%b required 1 0", ovf_err, len_err);
        end
        checks++;
        if (m_a_tvalid !== 1'b1 || m_a_tdata !== da(3, 0)) begin
            errors++;
            $display("FAIL ovf_head: valid=%b data=%h required 1 %h", m_a_tvalid, m_a_tdata, da(3, 0));
        end
        m_a_tready = 1'b1; m_b_tready = 1'b1;
        wait_frames(16'd4, 2000);
        repeat (10) @(posedge clk);
        #1;
        bad = count_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ovf_data: bad beats=%0d (a=%0d b=%0d) required 0", bad, qa.size(), qb.size());
        end
        checks++;
        if (m_a_tvalid !== 1'b0 || frames_sent !== 16'd4) begin
            errors++;
            $display("FAIL ovf_drain: valid=%b frames=%0d required 0 4", m_a_tvalid, frames_sent);
        end
        pulse_clear();
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b required 0", ovf_err);
        end
    endtask

    task automatic test_len();
        int bad;
        clear_logs();
        send_frame(5, 200);
        checks++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_short: got %b required 1", len_err);
        end
        wait_frames(16'd5, 1000);
        pulse_clear();
        checks++;
        if (len_err !== 1'b0) begin
            errors++;
            $display("FAIL len_clear: got %b required 0", len_err);
        end
        send_frame(6, 256);
        wait_frames(16'd6, 1000);
        checks++;
        if ({ovf_err, len_err, sync_err} !== 3'b000 || frames_sent !== 16'd6) begin
            errors++;
            $display("FAIL len_clean: flags=%b frames=%0d required 000 6", {ovf_err, len_err, sync_err}, frames_sent);
        end
        bad = count_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL len_data: bad beats=%0d required 0", bad);
        end
    endtask

    task automatic test_reconfig();
        int bad;
        int n0;
        clear_logs();
        n0 = cfg_cyc.size();
        m_a_tready = 1'b1; m_b_tready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            reconfig = (i == 100);
            drive(1'b1, 1'b1, da(7, i), db(7, i), i == 255);
            exp_q.push_back({i == 255, db(7, i), da(7, i)});
        end
        reconfig = 1'b0;
        send_frame(8, 256);
        m_b_tready = 1'b1;
        wait_frames(16'd8, 3000);
        checks++;
        if (cfg_cyc.size() != n0 + 1) begin
            errors++;
            $display("FAIL rcfg_count: cfg beats=%0d required %0d", cfg_cyc.size(), n0 + 1);
        end
        checks++;
        if (qa.size() < 257 || qb.size() < 257 || cfg_cyc.size() <= n0) begin
            errors++;
            $display("FAIL rcfg_beats: a=%0d b=%0d cfg=%0d required 512 512 %0d", qa.size(), qb.size(), cfg_cyc.size(), n0 + 1);
        end else begin
            checks++;
            if (!(qb_cyc[255] < cfg_cyc[n0] && qa_cyc[255] < cfg_cyc[n0])) begin
                errors++;
                $display("FAIL rcfg_after_last: last a@%0d b@%0d cfg@%0d required cfg later", qa_cyc[255], qb_cyc[255], cfg_cyc[n0]);
            end
            checks++;
            if (!(qb_cyc[256] > cfg_cyc[n0] && qa_cyc[256] > cfg_cyc[n0])) begin
                errors++;
                $display("FAIL rcfg_before_next: next a@%0d b@%0d cfg@%0d required cfg earlier", qa_cyc[256], qb_cyc[256], cfg_cyc[n0]);
            end
        end
        bad = count_bad();
        checks++;
        if (bad !== 0 || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL rcfg_data: bad beats=%0d ovf=%b required 0 0", bad, ovf_err);
        end
    endtask

    task automatic test_sync_reset();
        int bad;
        clear_logs();
        m_a_tready = 1'b0; m_b_tready = 1'b0;
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'b1, da(9, i), db(9, i), 1'b0);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL sync_idle: got %b required 0", sync_err);
        end
        drive(1'b1, 1'b0, da(9, 10), db(9, 10), 1'b0);
        checks++;
        if (sync_err !== 1'b1) begin
            errors++;
            $display("FAIL sync_set: got %b required 1", sync_err);
        end
        clear_status = 1'b1;
        drive(1'b1, 1'b0, da(9, 11), db(9, 11), 1'b0);
        checks++;
        if (sync_err !== 1'b1) begin
            errors++;
            $display("FAIL sync_wins: got %b required 1", sync_err);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        clear_status = 1'b0;
        checks++;
        if (sync_err !== 1'b0 || m_a_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL sync_clear: sync=%b a_valid=%b required 0 1", sync_err, m_a_tvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_a_tvalid !== 1'b0 || m_b_tvalid !== 1'b0 || m_cfg_tvalid !== 1'b0 ||
            m_a_tdata !== 32'h0 || m_a_tlast !== 1'b0 || frames_sent !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid: a=%b b=%b cfg=%b data=%h last=%b frames=%0d required all 0",
                     m_a_tvalid, m_b_tvalid, m_cfg_tvalid, m_a_tdata, m_a_tlast, frames_sent);
        end
        @(posedge clk); #1;
        cfg_cyc.delete();
        rst_n = 1'b1;
        m_a_tready = 1'b1; m_b_tready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (cfg_cyc.size() != 1 || qa.size() != 0 || qb.size() != 0 || m_a_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_recfg: cfg=%0d a=%0d b=%0d valid=%b required 1 0 0 0",
                     cfg_cyc.size(), qa.size(), qb.size(), m_a_tvalid);
        end
        send_frame(10, 256);
        wait_frames(16'd1, 1000);
        bad = count_bad();
        checks++;
        if (bad !== 0 || frames_sent !== 16'd1) begin
            errors++;
            $display("FAIL rst_after: bad beats=%0d frames=%0d required 0 1", bad, frames_sent);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_len();
        test_reconfig();
        test_sync_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
